// File: rtl/hoplite_pkt_pkg.sv
// Shared Hoplite packet definitions: mode codes, FSM states, LFSR constants,
// and pack/unpack helpers for the {dst_x, dst_y, src_x, src_y, seq} layout.
// Helpers work on a 64-bit container, so packets wider than 64 bits are not supported.
package hoplite_pkt_pkg;

    localparam int MODE_TABLE = 0;
    localparam int MODE_LFSR  = 1;
    localparam int MODE_FIX   = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} pe_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [63:0] field_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // aw is the full {x,y} address width; seq fills whatever bits remain
    function automatic logic [63:0] pkt_pack(input int pw, input int aw,
                                             input logic [31:0] dst,
                                             input logic [31:0] src,
                                             input logic [63:0] seq);
        return (64'(dst) << (pw - aw)) | (64'(src) << (pw - 2*aw)) |
               (seq & field_mask(pw - 2*aw));
    endfunction

    function automatic logic [63:0] pkt_dst(input logic [63:0] p, input int pw, input int aw);
        return (p >> (pw - aw)) & field_mask(aw);
    endfunction

    function automatic logic [63:0] pkt_src(input logic [63:0] p, input int pw, input int aw);
        return (p >> (pw - 2*aw)) & field_mask(aw);
    endfunction

    function automatic logic [63:0] pkt_seq(input logic [63:0] p, input int pw, input int aw);
        return p & field_mask(pw - 2*aw);
    endfunction

endpackage

// File: rtl/pe_lfsr.sv
// 16-bit Galois LFSR with load-at-reset seed and step enable.
// nxt exposes the value the register will take on the next enabled step.
module pe_lfsr
    import hoplite_pkt_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state,
    output logic [15:0] nxt
);

    assign nxt = lfsr_step(state);

    // advance only when the owner consumes a value
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     state <= SEED;
        else if (en) state <= nxt;
    end

endmodule

// File: rtl/pe_traffic_gen.sv
// Hoplite torus PE: synthetic traffic source plus packet sink.
// Optional in-order delivery checker enabled by defining PE_RX_CHECK_EN.
// P_W must be >= 2*(X_AW+Y_AW)+1 and <= 64.
module pe_traffic_gen
    import hoplite_pkt_pkg::*;
#(
    parameter int P_W     = 16,
    parameter int X_AW    = 2,
    parameter int Y_AW    = 2,
    parameter int X_POS   = 0,
    parameter int Y_POS   = 0,
    parameter int N_PKT   = 10,
    parameter int MODE    = 0,
    parameter int FIX_DST = 1,
    parameter int GAP     = 0,
    parameter int CNT_W   = 16,
    localparam int AW     = X_AW + Y_AW,
    localparam int IDX_W  = (N_PKT > 1) ? $clog2(N_PKT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [AW-1:0]    cfg_dst,
    input  logic [P_W-1:0]   in_pkt,
    input  logic             in_vld,
    input  logic             sw_rdy,
    output logic [P_W-1:0]   out_pkt,
    output logic             out_vld,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt,
    output logic             rx_err
);

    localparam int SEQ_W  = P_W - 2*AW;
    localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [AW-1:0] OWN  = AW'((X_POS << Y_AW) | Y_POS);
    localparam logic [15:0]   SEED = LFSR_SEED ^ 16'(OWN);

    pe_state_e        state, state_nxt;
    logic [SEQ_W-1:0] seq, seq_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      lfsr, lfsr_nxt, lfsr_n;
    logic [AW-1:0]    dst_n;
    logic [P_W-1:0]   pkt_n;
    logic             go, xfer, last, load;
    logic [AW-1:0]    tbl [N_PKT];

    assign go   = start & ((state == ST_IDLE) | (state == ST_DONE));
    assign xfer = out_vld & sw_rdy;
    assign last = (tx_cnt == CNT_W'(N_PKT - 1));
    // a new packet is latched whenever SEND is (re)entered or continues back-to-back
    assign load = go | (xfer & ~last & (GAP == 0)) |
                  ((state == ST_WAIT) & (gap_cnt == '0));

    pe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (xfer),
        .state (lfsr),
        .nxt   (lfsr_nxt)
    );

    // values of seq/idx/lfsr as they will be after this edge, used to build the next packet
    always_comb begin
        seq_n  = go ? '0 : (xfer ? seq + 1'b1 : seq);
        idx_n  = go ? '0 : (xfer ? idx + 1'b1 : idx);
        lfsr_n = xfer ? lfsr_nxt : lfsr;
    end

    // destination select; own address only avoided in random mode
    always_comb begin
        dst_n = '0;
        if (MODE == MODE_LFSR) begin
            dst_n = lfsr_n[AW-1:0];
            if (dst_n == OWN) dst_n[0] = ~dst_n[0];
        end else if (MODE == MODE_FIX) begin
            dst_n = AW'(FIX_DST);
        end else if (int'(idx_n) < N_PKT) begin
            dst_n = tbl[idx_n];
        end
        pkt_n = P_W'(pkt_pack(P_W, AW, 32'(dst_n), 32'(OWN), 64'(seq_n)));
    end

    // destination table: no reset, writes allowed at any time
    always_ff @(posedge clk) begin
        if (cfg_we && int'(cfg_addr) < N_PKT) tbl[cfg_addr] <= cfg_dst;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go) state_nxt = ST_SEND;
            ST_SEND: if (xfer) begin
                         if (last)         state_nxt = ST_DONE;
                         else if (GAP > 0) state_nxt = ST_WAIT;
                     end
            ST_WAIT: if (gap_cnt == '0) state_nxt = ST_SEND;
            ST_DONE: if (go) state_nxt = ST_SEND;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        out_vld = (state == ST_SEND);
        busy    = (state == ST_SEND) | (state == ST_WAIT);
        done    = (state == ST_DONE);
    end

    // transmit datapath: counters, gap timer and the held output packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pkt <= '0;
            tx_cnt  <= '0;
            seq     <= '0;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            seq <= seq_n;
            idx <= idx_n;
            if (go)        tx_cnt <= '0;
            else if (xfer) tx_cnt <= tx_cnt + 1'b1;
            if (xfer)                                     gap_cnt <= GAP_W'(GAP_M1);
            else if (state == ST_WAIT && gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
            if (load) out_pkt <= pkt_n;
        end
    end

    // saturating receive counter; every ejected packet is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          rx_cnt <= '0;
        else if (in_vld && rx_cnt != '1)  rx_cnt <= rx_cnt + 1'b1;
    end

    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_n;

`ifdef PE_RX_CHECK_EN
    logic [SEQ_W-1:0] exp_seq [1 << AW];
    logic [AW-1:0]    rx_dst, rx_src;
    logic [SEQ_W-1:0] rx_seq;

    assign rx_dst = AW'(pkt_dst(64'(in_pkt), P_W, AW));
    assign rx_src = AW'(pkt_src(64'(in_pkt), P_W, AW));
    assign rx_seq = SEQ_W'(pkt_seq(64'(in_pkt), P_W, AW));

    // per-source sequence tracker; resyncs to the received seq even after an error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) exp_seq[i] <= '0;
            rx_err <= 1'b0;
        end else if (in_vld) begin
            if (rx_dst != OWN || rx_seq != exp_seq[rx_src]) rx_err <= 1'b1;
            exp_seq[rx_src] <= rx_seq + 1'b1;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^in_pkt;
    assign rx_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Directed bench for pe_traffic_gen: three instances cover fixed, table and
// LFSR destination modes; rx checker expectations follow PE_RX_CHECK_EN.
module tb_pe_traffic_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUT A: MODE2, FIX_DST=1, N_PKT=4 ----------------
    logic        a_start = 0, a_we = 0, a_in_vld = 0, a_rdy = 0;
    logic [1:0]  a_addr = 0;
    logic [3:0]  a_cdst = 0;
    logic [15:0] a_in_pkt = 0, a_pkt, a_tx, a_rx;
    logic        a_vld, a_busy, a_done, a_err;

    pe_traffic_gen #(.P_W(16), .X_AW(2), .Y_AW(2), .X_POS(0), .Y_POS(0), .N_PKT(4),
                     .MODE(2), .FIX_DST(1), .GAP(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .cfg_we(a_we), .cfg_addr(a_addr),
        .cfg_dst(a_cdst), .in_pkt(a_in_pkt), .in_vld(a_in_vld), .sw_rdy(a_rdy),
        .out_pkt(a_pkt), .out_vld(a_vld), .busy(a_busy), .done(a_done),
        .tx_cnt(a_tx), .rx_cnt(a_rx), .rx_err(a_err));

    // ---------------- DUT B: MODE0 table, N_PKT=3, GAP=2 ----------------
    logic        b_start = 0, b_we = 0, b_in_vld = 0, b_rdy = 0;
    logic [1:0]  b_addr = 0;
    logic [3:0]  b_cdst = 0;
    logic [15:0] b_in_pkt = 0, b_pkt, b_tx, b_rx;
    logic        b_vld, b_busy, b_done, b_err;

    pe_traffic_gen #(.P_W(16), .X_AW(2), .Y_AW(2), .X_POS(0), .Y_POS(0), .N_PKT(3),
                     .MODE(0), .FIX_DST(1), .GAP(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .cfg_we(b_we), .cfg_addr(b_addr),
        .cfg_dst(b_cdst), .in_pkt(b_in_pkt), .in_vld(b_in_vld), .sw_rdy(b_rdy),
        .out_pkt(b_pkt), .out_vld(b_vld), .busy(b_busy), .done(b_done),
        .tx_cnt(b_tx), .rx_cnt(b_rx), .rx_err(b_err));

    // ---------------- DUT C: MODE1 LFSR, N_PKT=100 ----------------
    logic        c_start = 0, c_we = 0, c_in_vld = 0, c_rdy = 0;
    logic [6:0]  c_addr = 0;
    logic [3:0]  c_cdst = 0;
    logic [15:0] c_in_pkt = 0, c_pkt, c_tx, c_rx;
    logic        c_vld, c_busy, c_done, c_err;

    pe_traffic_gen #(.P_W(16), .X_AW(2), .Y_AW(2), .X_POS(0), .Y_POS(0), .N_PKT(100),
                     .MODE(1), .FIX_DST(1), .GAP(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .cfg_we(c_we), .cfg_addr(c_addr),
        .cfg_dst(c_cdst), .in_pkt(c_in_pkt), .in_vld(c_in_vld), .sw_rdy(c_rdy),
        .out_pkt(c_pkt), .out_vld(c_vld), .busy(c_busy), .done(c_done),
        .tx_cnt(c_tx), .rx_cnt(c_rx), .rx_err(c_err));

    typedef struct {
        logic        start;
        logic        rdy;
        logic        vld;
        logic [15:0] pkt;
        logic        busy;
        logic        done;
        logic [15:0] tx;
    } vec_t;

    vec_t va [14];

    function automatic vec_t mk(input logic s, input logic r, input logic v,
                                input logic [15:0] p, input logic b, input logic d,
                                input logic [15:0] t);
        vec_t x;
        x.start = s; x.rdy = r; x.vld = v; x.pkt = p; x.busy = b; x.done = d; x.tx = t;
        return x;
    endfunction

    logic [15:0] lf, exp_p;
    logic [3:0]  d;
    int          n;
    logic        b_rdy_s [1:9];
    logic        b_vld_e [1:9];
    logic [15:0] b_pkt_e [1:9];
    logic        exp_err;

    initial begin
        // A: back-to-back run, then a run with a 3-cycle stall on pkt 1 and an ignored start
        va[0]  = mk(1, 1, 1, 16'h1000, 1, 0, 0);
        va[1]  = mk(0, 1, 1, 16'h1001, 1, 0, 1);
        va[2]  = mk(0, 1, 1, 16'h1002, 1, 0, 2);
        va[3]  = mk(0, 1, 1, 16'h1003, 1, 0, 3);
        va[4]  = mk(0, 1, 0, 16'h0000, 0, 1, 4);
        va[5]  = mk(1, 0, 1, 16'h1000, 1, 0, 0);
        va[6]  = mk(0, 1, 1, 16'h1001, 1, 0, 1);
        va[7]  = mk(0, 0, 1, 16'h1001, 1, 0, 1);
        va[8]  = mk(1, 0, 1, 16'h1001, 1, 0, 1);
        va[9]  = mk(0, 0, 1, 16'h1001, 1, 0, 1);
        va[10] = mk(0, 1, 1, 16'h1002, 1, 0, 2);
        va[11] = mk(0, 1, 1, 16'h1003, 1, 0, 3);
        va[12] = mk(0, 1, 0, 16'h0000, 0, 1, 4);
        va[13] = mk(0, 1, 0, 16'h0000, 0, 1, 4);

        // B: sw_rdy per edge, expected out_vld/out_pkt after each edge
        b_rdy_s = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        b_vld_e = '{1, 0, 0, 1, 1, 0, 0, 1, 0};
        b_pkt_e = '{16'h5000, 0, 0, 16'h2001, 16'h2001, 0, 0, 16'h0002, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst_pkt",  32'(a_pkt),  0);
        chk("rst_vld",  32'(a_vld),  0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_tx",   32'(a_tx),   0);
        chk("rst_rx",   32'(a_rx),   0);
        chk("rst_err",  32'(a_err),  0);

        // rx path: src 3 with seq 0,1,3 addressed to (0,0)
`ifdef PE_RX_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        a_in_vld = 1; a_in_pkt = 16'h0300;
        @(posedge clk); #1;
        chk("rx_cnt1", 32'(a_rx), 1);
        chk("rx_err1", 32'(a_err), 0);
        a_in_pkt = 16'h0301;
        @(posedge clk); #1;
        chk("rx_cnt2", 32'(a_rx), 2);
        chk("rx_err2", 32'(a_err), 0);
        a_in_pkt = 16'h0303;
        @(posedge clk); #1;
        chk("rx_cnt3", 32'(a_rx), 3);
        chk("rx_err3", 32'(a_err), 32'(exp_err));
        a_in_vld = 0;
        @(posedge clk); #1;
        chk("rx_cnt_hold", 32'(a_rx), 3);
        chk("rx_err_sticky", 32'(a_err), 32'(exp_err));

        // A table-driven
        for (int i = 0; i < 14; i++) begin
            a_start = va[i].start;
            a_rdy   = va[i].rdy;
            @(posedge clk); #1;
            a_start = 0;
            chk($sformatf("a%0d_vld", i),  32'(a_vld),  32'(va[i].vld));
            if (va[i].vld) chk($sformatf("a%0d_pkt", i), 32'(a_pkt), 32'(va[i].pkt));
            chk($sformatf("a%0d_busy", i), 32'(a_busy), 32'(va[i].busy));
            chk($sformatf("a%0d_done", i), 32'(a_done), 32'(va[i].done));
            chk($sformatf("a%0d_tx", i),   32'(a_tx),   32'(va[i].tx));
        end
        a_rdy = 0;

        // B: program table {5,2,0}, then run with a mid-run table write and a stall
        b_we = 1; b_addr = 0; b_cdst = 4'd5;
        @(posedge clk); #1;
        b_addr = 1; b_cdst = 4'd2;
        @(posedge clk); #1;
        b_addr = 2; b_cdst = 4'd0;
        @(posedge clk); #1;
        b_we = 0;
        for (int e = 1; e <= 9; e++) begin
            b_start = (e == 1);
            b_rdy   = b_rdy_s[e];
            b_we    = (e == 5);
            b_addr  = 1; b_cdst = 4'd9;
            @(posedge clk); #1;
            b_start = 0; b_we = 0;
            chk($sformatf("b%0d_vld", e), 32'(b_vld), 32'(b_vld_e[e]));
            if (b_vld_e[e]) chk($sformatf("b%0d_pkt", e), 32'(b_pkt), 32'(b_pkt_e[e]));
        end
        chk("b_done", 32'(b_done), 1);
        chk("b_tx",   32'(b_tx),   3);
        b_rdy = 0;

        // C: 100 random destinations against a reference LFSR
        lf = 16'hACE1;
        n  = 0;
        c_start = 1; c_rdy = 1;
        for (int cyc = 0; cyc < 300 && n < 100; cyc++) begin
            @(posedge clk); #1;
            c_start = 0;
            if (c_vld) begin
                d = lf[3:0];
                if (d == 4'd0) d = 4'd1;
                exp_p = {d, 4'h0, 8'(n)};
                chk($sformatf("c%0d_pkt", n), 32'(c_pkt), 32'(exp_p));
                chk($sformatf("c%0d_notown", n), 32'(c_pkt[15:12] != 4'd0), 1);
                lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
                n++;
            end
        end
        chk("c_count", n, 100);
        @(posedge clk); #1;
        chk("c_done", 32'(c_done), 1);
        chk("c_tx",   32'(c_tx),   100);
        c_rdy = 0;

        // A: async reset in the middle of a run, off the clock edge
        a_start = 1; a_rdy = 1;
        @(posedge clk); #1;
        a_start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_rdy = 0;
        chk("pre_rst_tx",  32'(a_tx),  2);
        chk("pre_rst_vld", 32'(a_vld), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld",  32'(a_vld),  0);
        chk("arst_busy", 32'(a_busy), 0);
        chk("arst_tx",   32'(a_tx),   0);
        chk("arst_rx",   32'(a_rx),   0);
        chk("arst_pkt",  32'(a_pkt),  0);
        chk("arst_err",  32'(a_err),  0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle_vld",  32'(a_vld),  0);
        chk("post_rst_idle_done", 32'(a_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
